// File: rtl/bmc_sched_if.sv
// Handshake bundle between the symbol source, the branch-metric scheduler and the ACS stage.
// rx_erase exists only when BMC_SCHED_ERASURE_EN is defined.
interface bmc_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] rx_pair;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] slot;
  logic [1:0] path_0_bmc;
  logic [1:0] path_1_bmc;
  logic [7:0] sym_idx;
  logic       frame_done;
`ifdef BMC_SCHED_ERASURE_EN
  logic       rx_erase;
`endif

  modport master (
    output in_valid, rx_pair, abort, out_ready,
`ifdef BMC_SCHED_ERASURE_EN
    output rx_erase,
`endif
    input  in_ready, out_valid, slot, path_0_bmc, path_1_bmc, sym_idx, frame_done
  );

  modport slave (
    input  in_valid, rx_pair, abort, out_ready,
`ifdef BMC_SCHED_ERASURE_EN
    input  rx_erase,
`endif
    output in_ready, out_valid, slot, path_0_bmc, path_1_bmc, sym_idx, frame_done
  );
endinterface

// File: rtl/bmc_sched.sv
// Branch-metric scheduler: each received symbol is presented as 8 slots of Hamming metrics.
// Optional BMC_SCHED_ERASURE_EN adds rx_erase, which forces all metrics of a symbol to 0.
module bmc_sched #(
  parameter int FRAME_LEN = 16
) (
  input logic        clk,
  input logic        rst_n,
  bmc_sched_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam logic [7:0] LAST  = 8'(FRAME_LEN - 1);
  // E0[0..7] = 00,11,10,01,11,00,01,10 (index 7 listed first)
  localparam logic [7:0][1:0] E0 = {2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00};

  logic [0:0] state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] sym_q, sym_d;
  logic [1:0] rx_q, rx_d;
  logic       fd_q, fd_d;
  logic       issue, last_slot, last_sym, mask;
  logic [1:0] e, d0, d1;
`ifdef BMC_SCHED_ERASURE_EN
  logic       er_q, er_d;
`endif

  assign issue     = (state_q == ISSUE);
  assign last_slot = (slot_q == 3'd7);
  assign last_sym  = (sym_q == LAST);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sym_d   = sym_q;
    rx_d    = rx_q;
    fd_d    = 1'b0;
`ifdef BMC_SCHED_ERASURE_EN
    er_d    = er_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      slot_d  = 3'd0;
      sym_d   = 8'd0;
      rx_d    = 2'b00;
`ifdef BMC_SCHED_ERASURE_EN
      er_d    = 1'b0;
`endif
    end else if (!issue) begin
      if (bus.in_valid) begin
        state_d = ISSUE;
        slot_d  = 3'd0;
        rx_d    = bus.rx_pair;
`ifdef BMC_SCHED_ERASURE_EN
        er_d    = bus.rx_erase;
`endif
      end
    end else if (bus.out_ready) begin
      if (!last_slot) begin
        slot_d = slot_q + 3'd1;
      end else begin
        slot_d = 3'd0;
        if (last_sym) begin
          sym_d   = 8'd0;
          fd_d    = 1'b1;
          state_d = IDLE;
        end else begin
          sym_d = sym_q + 8'd1;
          // back-to-back symbol loads without a bubble
          if (bus.in_valid) begin
            rx_d = bus.rx_pair;
`ifdef BMC_SCHED_ERASURE_EN
            er_d = bus.rx_erase;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= 3'd0;
      sym_q   <= 8'd0;
      rx_q    <= 2'b00;
      fd_q    <= 1'b0;
`ifdef BMC_SCHED_ERASURE_EN
      er_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sym_q   <= sym_d;
      rx_q    <= rx_d;
      fd_q    <= fd_d;
`ifdef BMC_SCHED_ERASURE_EN
      er_q    <= er_d;
`endif
    end
  end

  // Metrics read 0 outside ISSUE so reset/idle values are all-zero.
`ifdef BMC_SCHED_ERASURE_EN
  assign mask = issue && !er_q;
`else
  assign mask = issue;
`endif
  assign e  = E0[slot_q];
  assign d0 = rx_q ^ e;
  assign d1 = rx_q ^ ~e;

  assign bus.in_ready   = !issue || (last_slot && bus.out_ready && !bus.abort && !last_sym);
  assign bus.out_valid  = issue;
  assign bus.slot       = slot_q;
  assign bus.sym_idx    = sym_q;
  assign bus.frame_done = fd_q;
  assign bus.path_0_bmc = mask ? {&d0, ^d0} : 2'b00;
  assign bus.path_1_bmc = mask ? {&d1, ^d1} : 2'b00;
endmodule

// File: doc/bmc_sched.md
BMC_SCHED -- requirements
Module: bmc_sched

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, giving the number of symbols per frame (legal range 1..256).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: rx_pair holds a received symbol.
REQ-005 SHALL have port in_ready, output, 1 bit: the scheduler accepts a symbol this cycle.
REQ-006 SHALL have port rx_pair, input, 2 bits: received code bits; bit 0 is the first bit, bit 1 the second.
REQ-007 SHALL have port abort, input, 1 bit: synchronous frame abort.
REQ-008 SHALL have port out_valid, output, 1 bit: the slot metrics are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the ACS stage accepts the slot metrics.
REQ-010 SHALL have port slot, output, 3 bits: index (0..7) of the branch-metric slot being presented.
REQ-011 SHALL have port path_0_bmc, output, 2 bits: branch metric against expected codeword E0[slot].
REQ-012 SHALL have port path_1_bmc, output, 2 bits: branch metric against ~E0[slot].
REQ-013 SHALL have port sym_idx, output, 8 bits: index of the current symbol within the frame.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of the frame.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and ISSUE.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid 0; when in_valid && !abort, SHALL latch rx_pair, set slot=0 and enter ISSUE.
REQ-017 In ISSUE, out_valid SHALL be 1; each out_valid && out_ready handshake SHALL advance slot by 1.
REQ-018 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-019 The expected codeword table SHALL be E0[0..7] = 00,11,10,01,11,00,01,10.
REQ-020 Each metric SHALL be the Hamming distance between the latched rx_pair and its expected codeword, 0..2, encoded {both bits differ, exactly one bit differs}.
REQ-021 Latency: first slot SHALL be valid the cycle after acceptance; a symbol takes 8 handshakes.
REQ-022 In ISSUE at slot 7, in_ready SHALL equal out_ready && !abort && (sym_idx != FRAME_LEN-1).
- If in_valid is also high, the new symbol SHALL load with slot=0 and ISSUE continues with no bubble.
REQ-023 On the slot-7 handshake, sym_idx SHALL increment.
- If sym_idx == FRAME_LEN-1, it SHALL instead wrap to 0.
- In that case frame_done SHALL pulse for exactly one cycle (the next cycle) and the FSM SHALL return to IDLE.
REQ-024 When abort=1 in any state, the next state SHALL be IDLE.
- sym_idx and slot SHALL clear to 0, the latched symbol SHALL be discarded, and frame_done SHALL not pulse.
- abort SHALL take priority over simultaneous in_valid or handshake.
REQ-025 FRAME_LEN=1 SHALL return to IDLE after every symbol.

Reset
REQ-026 While rst_n=0, the scheduler SHALL hold: state=IDLE, in_ready=1, out_valid=0, slot=0, path_0_bmc=0, path_1_bmc=0, sym_idx=0, frame_done=0, latched symbol=00.
REQ-027 Reset asserted mid-symbol SHALL drop that symbol.
- The first cycle after deassertion SHALL behave as IDLE.

Configuration
REQ-028 With BMC_SCHED_ERASURE_EN defined, SHALL add input rx_erase (1 bit), sampled with rx_pair.
- For an erased symbol, both metrics SHALL be 0 for all 8 slots.
- Without the macro, the port SHALL be absent and metrics SHALL always follow REQ-020.

Verification
REQ-029 Reset, then rx_pair=00 with out_ready=1 -> path_0_bmc sequence 0,2,1,1,2,0,1,1 and path_1_bmc sequence 2,0,1,1,0,2,1,1 on slots 0..7.
REQ-030 out_ready low 3 cycles at slot 4 -> slot, metrics and out_valid held; resumes at slot 4 with no slot lost.
REQ-031 FRAME_LEN=4, continuous in_valid -> 32 consecutive out_valid cycles, sym_idx 0..3, frame_done pulse once, in_ready=0 on final slot 7.
REQ-032 abort asserted at slot 3 of symbol 2 -> IDLE next cycle, sym_idx=0, no frame_done; next symbol starts at slot 0.
REQ-033 rst_n pulsed low mid-ISSUE -> all outputs at reset values immediately (asynchronously); ERASURE build: rx_erase=1 -> all 16 metrics 0.
